// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the dest-bit demux / mux arbiter pair: FSM encoding
// and the default word width both sides agree on.
package mux_arbiter_pkg;

  localparam int DATA_SIZE_DEF = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

endpackage

// File: rtl/mux_arbiter_d.sv
// Converges two FWFT destination FIFOs into one registered push stream using a
// burst-limited round-robin FSM with downstream back-pressure.
module mux_arbiter_d
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int BURST     = 4,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty_d0,
  input  logic                 empty_d1,
  input  logic [DATA_SIZE-1:0] data_d0,
  input  logic [DATA_SIZE-1:0] data_d1,
  input  logic                 almost_full_out,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push_out,
  output logic [CNT_SIZE-1:0]  count_d0,
  output logic [CNT_SIZE-1:0]  count_d1,
  output logic                 busy
);

  localparam int BW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_L = BW'(BURST);
  localparam logic [BW-1:0] ONE     = BW'(1);

  state_t              state, state_n;
  logic [BW-1:0]       burst, burst_n;
  logic                last, last_n;
  logic                grant0, grant1;
  logic                pick0;

  logic [DATA_SIZE-1:0] data_p1;
  logic                 vld_p1;
  logic [CNT_SIZE-1:0]  cnt0_p1, cnt1_p1;
  logic                 busy_p1;

  // Stage 0: pop decision, made in the same cycle the FIFO heads are presented
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    pick0   = 1'b0;
    state_n = state;
    burst_n = burst;
    last_n  = last;
    if (!reset && !almost_full_out) begin
      case (state)
        IDLE: begin
          // last==1 means d0 is preferred; fall back to the other port if preferred is empty
          pick0 = last ? !empty_d0 : (empty_d1 && !empty_d0);
          if (pick0) begin
            grant0  = 1'b1;
            state_n = SERVE0;
            burst_n = ONE;
          end else if (!empty_d1) begin
            grant1  = 1'b1;
            state_n = SERVE1;
            burst_n = ONE;
          end
        end
        SERVE0: begin
          if (!empty_d0 && ((burst < BURST_L) || empty_d1)) begin
            grant0  = 1'b1;
            burst_n = (burst == BURST_L) ? ONE : burst + ONE;
          end else if (!empty_d1) begin
            grant1  = 1'b1;
            state_n = SERVE1;
            burst_n = ONE;
          end else begin
            state_n = IDLE;
            last_n  = 1'b0;
          end
        end
        SERVE1: begin
          if (!empty_d1 && ((burst < BURST_L) || empty_d0)) begin
            grant1  = 1'b1;
            burst_n = (burst == BURST_L) ? ONE : burst + ONE;
          end else if (!empty_d0) begin
            grant0  = 1'b1;
            state_n = SERVE0;
            burst_n = ONE;
          end else begin
            state_n = IDLE;
            last_n  = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign pop_d0 = grant0;
  assign pop_d1 = grant1;

  // Stage 1: registered FSM context, forwarded word and observability counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      burst   <= '0;
      last    <= 1'b1;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      cnt0_p1 <= '0;
      cnt1_p1 <= '0;
      busy_p1 <= 1'b0;
    end else begin
      state   <= state_n;
      burst   <= burst_n;
      last    <= last_n;
      vld_p1  <= grant0 | grant1;
      busy_p1 <= (state_n != IDLE);
      if (grant0) begin
        data_p1 <= data_d0;
      end else if (grant1) begin
        data_p1 <= data_d1;
      end else begin
        data_p1 <= '0;
      end
      if (grant0) begin
        cnt0_p1 <= cnt0_p1 + CNT_SIZE'(1);
      end
      if (grant1) begin
        cnt1_p1 <= cnt1_p1 + CNT_SIZE'(1);
      end
    end
  end

  assign data_out = data_p1;
  assign push_out = vld_p1;
  assign count_d0 = cnt0_p1;
  assign count_d1 = cnt1_p1;
  assign busy     = busy_p1;

endmodule

// File: tb/tb_mux_arbiter_d.sv
// Self-checking bench for mux_arbiter_d: queue-backed FIFO models feed the DUT
// and a port-level arbitration model predicts pops, pushes and counters.
module tb_mux_arbiter_d;

  localparam int DW    = 6;
  localparam int BURST = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          empty_d0 = 1'b1, empty_d1 = 1'b1;
  logic [DW-1:0] data_d0 = '0, data_d1 = '0;
  logic          almost_full_out = 1'b0;
  logic          pop_d0, pop_d1, push_out, busy;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count_d0, count_d1;

  mux_arbiter_d #(.DATA_SIZE(DW), .BURST(BURST), .CNT_SIZE(CW)) dut (
    .clk(clk), .reset(reset),
    .empty_d0(empty_d0), .empty_d1(empty_d1),
    .data_d0(data_d0), .data_d1(data_d1),
    .almost_full_out(almost_full_out),
    .pop_d0(pop_d0), .pop_d1(pop_d1),
    .data_out(data_out), .push_out(push_out),
    .count_d0(count_d0), .count_d1(count_d1),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q0[$], q1[$];
  int cur = -1, last_m = 1, run_m = 0;
  int cnt0_m = 0, cnt1_m = 0;
  int checks = 0, errors = 0;
  int push_run = 0, max_run = 0, pushes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has(input int p);
    return (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
  endfunction

  // Which port the arbiter should consume this cycle, -1 for none.
  function automatic int predict(input bit af, input bit rst);
    int other;
    if (rst || af) return -1;
    if (cur < 0) begin
      if (has(1 - last_m)) return 1 - last_m;
      if (has(last_m)) return last_m;
      return -1;
    end
    other = 1 - cur;
    if (has(cur) && (run_m < BURST || !has(other))) return cur;
    if (has(other)) return other;
    return -1;
  endfunction

  // One clock: present FIFO heads at the falling edge, check pops, then check
  // the registered results just after the rising edge.
  task automatic step(input bit af, input bit rst);
    int g;
    logic [DW-1:0] exp_data;
    reset = rst;
    almost_full_out = af;
    empty_d0 = (q0.size() == 0);
    empty_d1 = (q1.size() == 0);
    data_d0  = (q0.size() > 0) ? q0[0] : '0;
    data_d1  = (q1.size() > 0) ? q1[0] : '0;
    #1;
    g = predict(af, rst);
    chk("pop_d0", {31'b0, pop_d0}, {31'b0, g == 0});
    chk("pop_d1", {31'b0, pop_d1}, {31'b0, g == 1});
    @(posedge clk);
    #1;
    exp_data = '0;
    if (rst) begin
      cur = -1; last_m = 1; run_m = 0; cnt0_m = 0; cnt1_m = 0;
      q0.delete(); q1.delete();
    end else begin
      if (g == 0) begin exp_data = q0.pop_front(); cnt0_m = (cnt0_m + 1) % (1 << CW); end
      if (g == 1) begin exp_data = q1.pop_front(); cnt1_m = (cnt1_m + 1) % (1 << CW); end
      if (g >= 0) begin
        if (g == cur) run_m = (run_m == BURST) ? 1 : run_m + 1;
        else begin cur = g; run_m = 1; end
      end else if (!af && cur >= 0) begin
        last_m = cur;
        cur = -1;
      end
    end
    chk("push_out", {31'b0, push_out}, {31'b0, g >= 0});
    chk("data_out", {26'b0, data_out}, {26'b0, exp_data});
    chk("count_d0", {24'b0, count_d0}, cnt0_m);
    chk("count_d1", {24'b0, count_d1}, cnt1_m);
    chk("busy", {31'b0, busy}, {31'b0, cur >= 0});
    if (push_out) begin
      push_run++; pushes++;
      if (push_run > max_run) max_run = push_run;
    end else push_run = 0;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && cur < 0) break;
      step(1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_push", {31'b0, push_out}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);

    // Three words through d0 only
    q0.push_back(6'h05); q0.push_back(6'h06); q0.push_back(6'h07);
    drain(10);
    chk("t1_count_d0", {24'b0, count_d0}, 32'd3);
    chk("t1_idle", {31'b0, busy}, 32'd0);
    chk("t1_last", last_m, 32'd0);

    // After reset, a lone d1 word is taken immediately
    step(1'b0, 1'b1);
    q1.push_back(6'h2a);
    step(1'b0, 1'b0);
    chk("t4_count_d1", {24'b0, count_d1}, 32'd1);
    chk("t4_data", {26'b0, data_out}, 32'h2a);
    drain(5);
    chk("t4_last", last_m, 32'd1);

    // Both FIFOs full: continuous stream, no bubbles
    for (int i = 0; i < 10; i++) begin
      q0.push_back(DW'(i));
      q1.push_back(DW'(6'h20 + i));
    end
    max_run = 0; push_run = 0; pushes = 0;
    drain(40);
    chk("t2_run_len", max_run, 32'd20);
    chk("t2_pushes", pushes, 32'd20);

    // Back-pressure in the middle of a burst
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'($urandom));
      q1.push_back(DW'($urandom));
    end
    pushes = 0;
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    drain(30);
    chk("t3_no_loss", pushes, 32'd12);

    // Reset while serving d1 with two words already granted
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) q1.push_back(DW'(6'h10 + i));
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("t5_pre_cur", cur, 32'd1);
    chk("t5_pre_run", run_m, 32'd2);
    q0.push_back(6'h01);
    step(1'b0, 1'b1);
    chk("t5_push", {31'b0, push_out}, 32'd0);
    chk("t5_data", {26'b0, data_out}, 32'd0);
    chk("t5_cnt1", {24'b0, count_d1}, 32'd0);
    q0.push_back(6'h11); q1.push_back(6'h22);
    step(1'b0, 1'b0);
    chk("t5_first_d0", {24'b0, count_d0}, 32'd1);
    drain(10);

    // Random arrivals and back-pressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 16) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 16) q1.push_back(DW'($urandom));
      step($urandom_range(0, 4) == 0, 1'b0);
    end
    drain(80);

    // 256 single words through d0: counter wraps
    step(1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      q0.push_back(DW'(i));
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("t6_wrap_d0", {24'b0, count_d0}, 32'd0);
    chk("t6_d1_zero", {24'b0, count_d1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
